// File: rtl/unsigned_mul_seq_if.sv
// Operand/result bundle for unsigned_mul_seq.
// master: drives start, A, B and receives busy, done, product.
// slave : the multiplier side.
// With UMUL_ROUND_EN defined, product_rnd (N bits) is carried as well.
interface unsigned_mul_seq_if #(
  parameter int N = 24
);
  logic           start;
  logic [N-1:0]   A;
  logic [N-1:0]   B;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;
`ifdef UMUL_ROUND_EN
  logic [N-1:0]   product_rnd;
`endif

`ifdef UMUL_ROUND_EN
  modport master (output start, A, B, input busy, done, product, product_rnd);
  modport slave  (input start, A, B, output busy, done, product, product_rnd);
`else
  modport master (output start, A, B, input busy, done, product);
  modport slave  (input start, A, B, output busy, done, product);
`endif
endinterface

// File: rtl/unsigned_mul_seq.sv
// Sequential radix-2 shift-add unsigned multiplier (FP mantissa path).
// Ports:
//   clk  - clock, rising edge
//   rstn - synchronous active-low reset
//   bus  - unsigned_mul_seq_if.slave: start/A/B in, busy/done/product out
// One iteration per clock; start sampled in IDLE, done pulses N+1 clocks
// later with the full 2N-bit product, which is held until the next
// completion.
// Optional: UMUL_ROUND_EN adds product_rnd = upper half rounded half-up.
module unsigned_mul_seq #(
  parameter int N = 24
) (
  input  logic             clk,
  input  logic             rstn,
  unsigned_mul_seq_if.slave bus
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [N:0]     acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [2*N-1:0] product_q, product_d;
  logic [N:0]     sum;
`ifdef UMUL_ROUND_EN
  logic [N-1:0]   rnd_q, rnd_d;
`endif

  // Partial-product add keeps the carry in bit N.
  assign sum = acc_q + {1'b0, (mplier_q[0] ? mcand_q : {N{1'b0}})};

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    product_d = product_q;
`ifdef UMUL_ROUND_EN
    rnd_d     = rnd_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d  = bus.A;
          mplier_d = bus.B;
          acc_d    = '0;
          cnt_d    = CW'(N-1);
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        // Shift {sum, mplier} right: low product bits retire into mplier.
        acc_d    = {1'b0, sum[N:1]};
        mplier_d = {sum[0], mplier_q[N-1:1]};
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          product_d = {acc_d[N-1:0], mplier_d};
`ifdef UMUL_ROUND_EN
          // Upper half tops out at 2^N-2, so +1 cannot overflow.
          rnd_d     = product_d[2*N-1:N] + {{(N-1){1'b0}}, product_d[N-1]};
`endif
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
`ifdef UMUL_ROUND_EN
      rnd_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
`ifdef UMUL_ROUND_EN
      rnd_q     <= rnd_d;
`endif
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
`ifdef UMUL_ROUND_EN
  assign bus.product_rnd = rnd_q;
`endif
endmodule

// File: doc/unsigned_mul_seq.md
Name: unsigned_mul_seq

Overview:
- Sequential radix-2 shift-add unsigned multiplier for the floating-point arithmetic unit's mantissa path.
- Inverse-direction companion to the unit's sequential unsigned divider.
- Accepts two N-bit unsigned operands with a start/busy/done handshake and produces the full 2N-bit product after N iteration cycles.
- Sits between mantissa unpack and normalize/round in the FP multiply path.

Parameters:
- N, 24, operand width in bits (mantissa plus hidden bit); legal range 2..64.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rstn  input  1  reset, synchronous, active-low.
- start  input  1  request; sampled only when the block is idle.
- A  input  N  multiplicand, unsigned.
- B  input  N  multiplier, unsigned.
- busy  output  1  high while a multiply is in progress.
- done  output  1  one-cycle pulse; product valid.
- product  output  2N  full unsigned product A*B; held until the next accepted start.

Behaviour:
- Interface: one clock (clk); reset rstn is synchronous and active-low. rstn=0 at a rising edge forces state=IDLE and all registers to 0: busy=0, done=0, product=0.
- FSM states: IDLE, RUN.
- IDLE, start=1 at edge k:
  - latch mcand<=A, mplier<=B, acc (N+1 bits)<=0, cnt<=N-1.
  - state<=RUN, busy<=1.
  - product keeps its old value until completion.
- IDLE, start=0: hold all state.
- RUN, one iteration per edge:
  - sum = acc + (mplier[0] ? mcand : 0), N+1 bits, no loss of carry.
  - {acc, mplier} <= {sum, mplier} >> 1, where acc receives sum[N:1] zero-extended and mplier receives {sum[0], mplier[N-1:1]}.
  - cnt<=cnt-1.
- RUN, cnt==0: the final iteration executes and, on the same edge:
  - product<=final {acc[N-1:0], mplier}.
  - done<=1, busy<=0, state<=IDLE.
- Latency: start sampled at edge k; done and product valid in the cycle after edge k+N. Total latency N+1 clocks from start.
- done is high for exactly one cycle and cleared on the next edge unless a new completion occurs.
- start while busy=1 is ignored; the operation in flight is unaffected. A/B changing mid-operation have no effect because operands are latched.
- start in the done cycle is accepted because the state is IDLE. Back-to-back throughput is one result per N+1 cycles.
- Arithmetic:
  - exact, no truncation; max product (2^N-1)^2 fits in 2N bits.
  - A=0 or B=0 gives product=0 with the same fixed latency (no early exit).
- rstn=0 mid-RUN aborts the operation: busy=0, done=0, product=0, state=IDLE on that edge.
- rstn=0 coinciding with start: reset wins and start is dropped.

Optional Feature:
- Macro: UMUL_ROUND_EN.
- When defined, adds output product_rnd (N bits), registered together with product:
  - product_rnd = product[2N-1:N] + product[N-1] (round-half-up of the upper half).
  - This never overflows N bits, since the maximum upper half is 2^N-2.
  - Reset value is 0; it updates only on completion.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Test Plan:
- N=24, reset, then start with A=3, B=5 -> busy=1 for 24 cycles; done pulse 25 cycles after start; product=15.
- A=B=0xFFFFFF -> product=0xFFFFFE000001 (with UMUL_ROUND_EN, product_rnd=0xFFFFFE); A=0, B=0x123456 -> product=0 at the same latency.
- Start A=7, B=9; pulse start with A=2, B=2 at cycle 5 -> ignored; done once with product=63.
- Start asserted in the done cycle with A=0x800000, B=2 -> accepted; second done 25 cycles later with product=0x1000000; first product held in between.
- Reset asserted 10 cycles into a multiply -> next edge busy=0, done=0, product=0; no done pulse follows; a fresh start then completes normally.
- With UMUL_ROUND_EN, A=0x800001, B=0x800000 -> product=0x400000800000 and product_rnd=0x400001. Without the macro, the same case gives product=0x400000800000 and no product_rnd port exists.
